// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, default widths and frame-size helpers for the ALU result serializer.
package alu_pkg;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    localparam int ALU_OUT_WIDTH  = 16;
    localparam int ALU_DATA_WIDTH = 8;
    function automatic int num_bytes(input int ow, input int dw);
        return ow / dw;
    endfunction
    function automatic int cnt_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction
endpackage

// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if: ALU result input, TX byte handshake and status flags.
interface alu_result_serializer_if
    import alu_pkg::*;
#(
    parameter int OUT_WIDTH  = ALU_OUT_WIDTH,
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) ();
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  OUT_VALID;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic                  BUSY;
    logic                  OVERFLOW;
    modport master (output ALU_OUT, OUT_VALID, TX_READY, input TX_DATA, TX_VALID, BUSY, OVERFLOW);
    modport slave  (input ALU_OUT, OUT_VALID, TX_READY, output TX_DATA, TX_VALID, BUSY, OVERFLOW);
endinterface

// File: rtl/alu_result_pending_buf.sv
// alu_result_pending_buf: one-entry holding register; a write in the same cycle as a clear keeps it full.
module alu_result_pending_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_OUT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= wr | (valid & ~rd);
            if (wr) data <= wr_data;
        end
    end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: splits each ALU result into LSB-first bytes over a valid/ready link,
// with a one-entry pending buffer and a drop flag for results that cannot be held.
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int OUT_WIDTH  = ALU_OUT_WIDTH,
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input logic                   CLK,
    input logic                   RST,
    alu_result_serializer_if.slave bus
);
    localparam int NUM_BYTES = num_bytes(OUT_WIDTH, DATA_WIDTH);
    localparam int CW        = cnt_width(NUM_BYTES);
    state_t               state_q, state_n;
    logic [OUT_WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic                 busy_q, ovf_q, ovf_n;
    logic                 pend_wr, pend_rd, pend_valid;
    logic [OUT_WIDTH-1:0] pend_data;
    logic                 hs, last;
    alu_result_pending_buf #(.WIDTH(OUT_WIDTH)) u_pend (
        .CLK     (CLK),
        .RST     (RST),
        .wr      (pend_wr),
        .wr_data (bus.ALU_OUT),
        .rd      (pend_rd),
        .valid   (pend_valid),
        .data    (pend_data)
    );
    assign hs   = (state_q == SEND) & bus.TX_READY;
    assign last = hs & (cnt_q == CW'(NUM_BYTES - 1));
    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        pend_wr = 1'b0;
        pend_rd = 1'b0;
        ovf_n   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.OUT_VALID) begin
                shift_n = bus.ALU_OUT;
                cnt_n   = '0;
                state_n = SEND;
            end
        end else if (last) begin
            // Frame boundary: pending takes priority, a fresh result refills pending.
            if (pend_valid) begin
                shift_n = pend_data;
                cnt_n   = '0;
                pend_rd = 1'b1;
                pend_wr = bus.OUT_VALID;
            end else if (bus.OUT_VALID) begin
                shift_n = bus.ALU_OUT;
                cnt_n   = '0;
            end else begin
                state_n = IDLE;
            end
        end else begin
            if (hs) begin
                shift_n = shift_q >> DATA_WIDTH;
                cnt_n   = cnt_q + 1'b1;
            end
            pend_wr = bus.OUT_VALID & ~pend_valid;
            ovf_n   = bus.OUT_VALID & pend_valid;
        end
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n == SEND) | pend_wr | (pend_valid & ~pend_rd);
            ovf_q   <= ovf_n;
        end
    end
    assign bus.TX_DATA  = shift_q[DATA_WIDTH-1:0];
    assign bus.TX_VALID = (state_q == SEND);
    assign bus.BUSY     = busy_q;
    assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed frames with a byte scoreboard checked by an independent monitor.
module tb_alu_result_serializer;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [7:0] sb[$];
    alu_result_serializer_if #(.OUT_WIDTH(16), .DATA_WIDTH(8)) bus ();
    alu_result_serializer #(.OUT_WIDTH(16), .DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );
    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every accepted byte must be the next one the scoreboard expects.
    always @(negedge CLK) begin
        if (RST && bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_byte: got %h expected none at %0t", bus.TX_DATA, $time);
            end else begin
                chk("tx_byte", {8'h0, bus.TX_DATA}, {8'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [15:0] v);
        bus.ALU_OUT   = v;
        bus.OUT_VALID = 1'b1;
        sb.push_back(v[7:0]);
        sb.push_back(v[15:8]);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {15'h0, bus.TX_VALID}, 16'h0);
        chk({name, "_busy"},  {15'h0, bus.BUSY},     16'h0);
    endtask

    initial begin
        bus.ALU_OUT   = '0;
        bus.OUT_VALID = 1'b0;
        bus.TX_READY  = 1'b0;
        #1;
        chk("rst_data", {8'h0, bus.TX_DATA}, 16'h0);
        chk("rst_valid", {15'h0, bus.TX_VALID}, 16'h0);
        chk("rst_busy", {15'h0, bus.BUSY}, 16'h0);
        chk("rst_ovf", {15'h0, bus.OVERFLOW}, 16'h0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        // 1: basic frame, ready always high
        bus.TX_READY = 1'b1;
        pulse(16'h1234);
        tick();
        bus.OUT_VALID = 1'b0;
        chk("t1_valid0", {15'h0, bus.TX_VALID}, 16'h1);
        chk("t1_byte0", {8'h0, bus.TX_DATA}, 16'h0034);
        chk("t1_busy", {15'h0, bus.BUSY}, 16'h1);
        tick();
        chk("t1_byte1", {8'h0, bus.TX_DATA}, 16'h0012);
        tick();
        chk_idle("t1_end");
        // 2: back-pressure holds the byte
        bus.TX_READY = 1'b0;
        pulse(16'hA55A);
        tick();
        bus.OUT_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {15'h0, bus.TX_VALID}, 16'h1);
            chk("t2_hold_data", {8'h0, bus.TX_DATA}, 16'h005A);
            tick();
        end
        bus.TX_READY = 1'b1;
        tick();
        chk("t2_byte1", {8'h0, bus.TX_DATA}, 16'h00A5);
        tick();
        chk_idle("t2_end");
        // 3: back-to-back results, no bubble
        pulse(16'h1111);
        tick();
        pulse(16'h2222);
        tick();
        bus.OUT_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_no_bubble", {15'h0, bus.TX_VALID}, 16'h1);
            chk("t3_ovf", {15'h0, bus.OVERFLOW}, 16'h0);
            tick();
        end
        chk_idle("t3_end");
        // 4: third result is dropped
        bus.TX_READY = 1'b0;
        pulse(16'h0001);
        tick();
        pulse(16'h0002);
        tick();
        bus.ALU_OUT   = 16'h0003;
        bus.OUT_VALID = 1'b1;
        chk("t4_ovf_pre", {15'h0, bus.OVERFLOW}, 16'h0);
        tick();
        bus.OUT_VALID = 1'b0;
        chk("t4_ovf_pulse", {15'h0, bus.OVERFLOW}, 16'h1);
        tick();
        chk("t4_ovf_clear", {15'h0, bus.OVERFLOW}, 16'h0);
        bus.TX_READY = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk_idle("t4_end");
        // 5: new result at last-byte acceptance with pending full
        bus.TX_READY = 1'b0;
        pulse(16'hBEEF);
        tick();
        pulse(16'hCAFE);
        tick();
        bus.OUT_VALID = 1'b0;
        bus.TX_READY  = 1'b1;
        tick();
        chk("t5_last_byte", {8'h0, bus.TX_DATA}, 16'h00BE);
        pulse(16'hF00D);
        tick();
        bus.OUT_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_ovf", {15'h0, bus.OVERFLOW}, 16'h0);
            chk("t5_valid", {15'h0, bus.TX_VALID}, 16'h1);
            tick();
        end
        chk_idle("t5_end");
        // 6: reset mid-frame aborts remaining bytes
        bus.TX_READY = 1'b0;
        pulse(16'hBEEF);
        tick();
        bus.OUT_VALID = 1'b0;
        bus.TX_READY  = 1'b1;
        tick();
        bus.TX_READY = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        sb.delete();
        chk("t6_rst_data", {8'h0, bus.TX_DATA}, 16'h0);
        chk("t6_rst_valid", {15'h0, bus.TX_VALID}, 16'h0);
        chk("t6_rst_busy", {15'h0, bus.BUSY}, 16'h0);
        chk("t6_rst_ovf", {15'h0, bus.OVERFLOW}, 16'h0);
        tick();
        RST = 1'b1;
        bus.TX_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("t6_quiet");
        end
        pulse(16'h5678);
        tick();
        bus.OUT_VALID = 1'b0;
        chk("t6_resume", {8'h0, bus.TX_DATA}, 16'h0078);
        tick();
        tick();
        chk_idle("t6_end");
        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream consumer of the ALU shift/arith/logic units.
- Captures each registered OUT_WIDTH-bit ALU result, qualified by its single-cycle OUT_VALID pulse.
- Splits the result into DATA_WIDTH-bit bytes, LSB byte first, and hands them one at a time to the UART TX path over a valid/ready handshake.
- A one-entry pending buffer absorbs a second result that arrives while a frame is being sent. Any further result is dropped and flagged.

Parameters:
- OUT_WIDTH, 16, width of the ALU result. Must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 8, width of one transmitted byte.
- NUM_BYTES, OUT_WIDTH/DATA_WIDTH, bytes per frame. Derived; do not override.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- ALU_OUT  in  OUT_WIDTH  ALU result.
- OUT_VALID  in  1  one-cycle pulse qualifying ALU_OUT.
- TX_DATA  out  DATA_WIDTH  byte offered to TX.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  TX accepts the byte this cycle.
- BUSY  out  1  a frame is in flight or pending.
- OVERFLOW  out  1  one-cycle pulse: a result was dropped.

Behaviour:
- Reset (async, RST=0): state=IDLE, shift register=0, byte counter=0, pending valid=0.
  - Outputs: TX_DATA=0, TX_VALID=0, BUSY=0, OVERFLOW=0.
  - Reset mid-frame aborts the frame. No residual bytes are sent after release.
- All outputs are registered.
- States:
  - IDLE: TX_VALID=0.
  - SEND: TX_VALID=1, TX_DATA = shift register [DATA_WIDTH-1:0].
- IDLE + OUT_VALID:
  - Load ALU_OUT into the shift register, clear the byte counter, go to SEND.
  - Latency: TX_VALID rises on the cycle after OUT_VALID.
- SEND, handshake (TX_VALID & TX_READY):
  - Shift register shifts right by DATA_WIDTH and the byte counter increments.
  - The next byte appears the following cycle.
- SEND, no handshake: TX_DATA and TX_VALID hold stable. TX_VALID never drops before acceptance.
- Last byte (counter = NUM_BYTES-1) accepted:
  - Pending valid: load pending into the shift register, clear pending, stay in SEND. No idle bubble.
  - Else, OUT_VALID in the same cycle: load ALU_OUT directly, stay in SEND.
  - Else: go to IDLE.
- OUT_VALID while in SEND (not the last-byte handshake case):
  - Pending empty: store into pending.
  - Pending full: drop the new result; OVERFLOW=1 next cycle for exactly one cycle. The stored pending entry is unchanged.
- OUT_VALID in the same cycle as last-byte acceptance with pending full:
  - Pending moves to the shift register and the new result enters pending.
  - No drop, no OVERFLOW.
- BUSY = (state != IDLE) | pending valid, registered alongside state.
- Byte counter: clog2(NUM_BYTES) bits (minimum 1), wraps to 0 on each frame load.
- No combinational path from TX_READY or OUT_VALID to any output.

Decomposition:
- Shared package alu_pkg:
  - state encoding: IDLE=1'b0, SEND=1'b1.
  - OUT_WIDTH/DATA_WIDTH defaults.
  - NUM_BYTES computation.
- Sub-module alu_result_pending_buf (one-entry holding register):
  - Ports: write, write data, read/clear, valid flag, data out.
  - Instantiated once.
- Everything else is flat.

Test Plan:
1. Reset, then ALU_OUT=16'h1234, OUT_VALID pulse, TX_READY=1 → cycle+1 TX_DATA=8'h34, TX_VALID=1; cycle+2 TX_DATA=8'h12; cycle+3 TX_VALID=0, BUSY=0.
2. ALU_OUT=16'hA55A, TX_READY=0 for 5 cycles then 1 → TX_DATA holds 8'h5A with TX_VALID=1 all 5 cycles; then 8'hA5 is sent, then IDLE.
3. TX_READY=1; pulses 16'h1111 at t0 and 16'h2222 at t1 → byte stream 11,11,22,22 on consecutive cycles with no bubble; OVERFLOW stays 0.
4. TX_READY=0; pulses 16'h0001, 16'h0002, 16'h0003 on three cycles → OVERFLOW=1 for one cycle after the third pulse; on release, bytes sent are 01,00,02,00 only.
5. Frame 16'hBEEF in progress with pending 16'hCAFE; new 16'hF00D pulsed in the same cycle as 8'hBE is accepted → stream EF,BE,FE,CA,0D,F0; no OVERFLOW.
6. Assert RST low mid-frame after 8'hEF of 16'hBEEF → all outputs 0 immediately; after release, nothing is sent until the next OUT_VALID.
